a_window_feeder: RTL and testbench

Streams a 20x20 pixel window into an `a_neuron` array as `z`/`en` control and five-pixel beats. It collects pixels from an upstream ready/valid source into a window buffer, then replays the window in the order the neuron consumes it. It is the producer end of the neuron's `z`/`en`/`d` interface. It also pulses `sample` in the cycle the neuron outputs (`q`) are valid for that window.

---
 rtl/a_pkg.sv | 17 +
 rtl/a_window_bank.sv | 23 ++
 rtl/a_window_feeder.sv | 150 +++++++++++++++
 tb/tb_a_window_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/a_pkg.sv
// rtl/a_pkg.sv - shared constants, pixel type and stream FSM states for the window feeder
package a_pkg;

  localparam int LANES  = 5;
  localparam int INPUTS = 400;
  localparam int BEATS  = INPUTS / LANES;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    STREAM,
    SAMPLE
  } feeder_state_t;

endpackage

// File: rtl/a_window_bank.sv
// rtl/a_window_bank.sv - one window of pixel storage, beat-wide write port and combinational read port
module a_window_bank
  import a_pkg::*;
#(
  localparam int AW = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  pixel_t [LANES-1:0]    wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output pixel_t [LANES-1:0]    rdata_o
);

  pixel_t [LANES-1:0] mem_q [BEATS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/a_window_feeder.sv
// rtl/a_window_feeder.sv - collects a pixel window and replays it as z/en/d beats to the neuron array
// A_FEEDER_PINGPONG_EN selects two ping-pong banks; default is a single bank.
module a_window_feeder
  import a_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  pixel_t [LANES-1:0] in_d,
  output logic               z,
  output logic               en,
  output pixel_t [LANES-1:0] d,
  output logic               sample,
  output logic               busy
);

  localparam int AW = $clog2(BEATS);
  localparam logic [AW-1:0] LAST = AW'(BEATS - 1);
`ifdef A_FEEDER_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  feeder_state_t      state_q, state_d;
  logic [AW-1:0]      fill_q, fill_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic               in_ready_q, in_ready_d;
  pixel_t [LANES-1:0] d_q, d_d;
  pixel_t [LANES-1:0] rdata [2];
  logic               accept;
  logic               fill_done;

  assign accept    = in_valid && in_ready_q && !clr;
  assign fill_done = accept && (fill_q == LAST);

  a_window_bank u_bank0 (
    .clk     (clk),
    .we_i    (accept && !wr_bank_q),
    .waddr_i (fill_q),
    .wdata_i (in_d),
    .raddr_i (rd_d),
    .rdata_o (rdata[0])
  );

`ifdef A_FEEDER_PINGPONG_EN
  a_window_bank u_bank1 (
    .clk     (clk),
    .we_i    (accept && wr_bank_q),
    .waddr_i (fill_q),
    .wdata_i (in_d),
    .raddr_i (rd_d),
    .rdata_o (rdata[1])
  );
`else
  assign rdata[1] = '0;
`endif

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    rd_d      = rd_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    d_d       = d_q;

    if (accept) begin
      fill_d = fill_done ? '0 : fill_q + AW'(1);
      if (fill_done) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = wr_bank_q ^ PINGPONG;
      end
    end

    // A window completing this very cycle counts as waiting, so z follows the last accept directly.
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q] || (fill_done && (wr_bank_q == rd_bank_q))) state_d = ZERO;
      end
      ZERO: begin
        state_d = STREAM;
        rd_d    = '0;
      end
      STREAM: begin
        if (rd_q == LAST) begin
          state_d = SAMPLE;
          rd_d    = '0;
        end else begin
          rd_d = rd_q + AW'(1);
        end
      end
      SAMPLE: begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = rd_bank_q ^ PINGPONG;
        if (full_q[~rd_bank_q] || (fill_done && (wr_bank_q != rd_bank_q))) state_d = ZERO;
        else                                                              state_d = IDLE;
      end
    endcase

    if (clr) begin
      state_d   = IDLE;
      fill_d    = '0;
      rd_d      = '0;
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
    end

    // d is loaded one cycle ahead so the registered value lines up with en.
    if (state_d == STREAM) d_d = rdata[rd_bank_q];

    in_ready_d = !full_d[wr_bank_d] && (PINGPONG || (state_d == IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      rd_q       <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      in_ready_q <= 1'b0;
      d_q        <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      rd_q       <= rd_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      in_ready_q <= in_ready_d;
      d_q        <= d_d;
    end
  end

  assign in_ready = in_ready_q;
  assign z        = (state_q == ZERO);
  assign en       = (state_q == STREAM);
  assign sample   = (state_q == SAMPLE);
  assign d        = d_q;
  assign busy     = (fill_q != '0) || (state_q != IDLE) || (|full_q);

endmodule

// File: tb/tb_a_window_feeder.sv
// tb/tb_a_window_feeder.sv - self-checking bench for a_window_feeder (both bank builds)
module tb_a_window_feeder;
  import a_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n, clr, in_valid, in_ready, z, en, sample, busy;
  pixel_t [LANES-1:0] in_d, d;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int zen_both = 0;

  int                 zq[$], sq[$], en_cyc[$];
  logic [LANES*8-1:0] en_dat[$];
  bit                 rdy_at[int];

  typedef struct packed {
    bit rst_n, clr, vld;
    bit e_rdy, e_busy, e_z, e_en, e_s;
  } vec_t;
  vec_t vec[6];

  a_window_feeder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_d     (in_d),
    .z        (z),
    .en       (en),
    .d        (d),
    .sample   (sample),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rdy_at[cyc] = in_ready;
    if (z && en) zen_both++;
    if (z) zq.push_back(cyc);
    if (en) begin
      en_cyc.push_back(cyc);
      en_dat.push_back(d);
    end
    if (sample) sq.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [LANES*8-1:0] beat_of(input pixel_t pix[INPUTS], input int r);
    logic [LANES*8-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*8 +: 8] = pix[r*LANES + l];
    return v;
  endfunction

  task automatic clear_mon();
    zq.delete(); sq.delete(); en_cyc.delete(); en_dat.delete();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rand_win(output pixel_t pix[INPUTS]);
    for (int i = 0; i < INPUTS; i++) pix[i] = pixel_t'($urandom);
  endtask

  // Presents one window; returns the cycle in which the final beat's handshake occurred.
  task automatic send_window(input pixel_t pix[INPUTS], input int gap_pct, output int last);
    int k = 0;
    int guard = 0;
    last = -1;
    while (k < BEATS && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_valid = ($urandom_range(99) >= gap_pct);
      for (int l = 0; l < LANES; l++) in_d[l] = pix[k*LANES + l];
      if (in_valid && in_ready) begin
        if (k == BEATS - 1) last = cyc;
        k++;
      end
    end
    if (k != BEATS) check("send_timeout", k, BEATS);
  endtask

  task automatic check_window(input pixel_t pix[INPUTS], input int zexp, input int idx, input string tag);
    int bad = 0;
    check({tag, "_z_cycle"}, (zq.size() > idx) ? zq[idx] : -1, zexp);
    check({tag, "_sample_cycle"}, (sq.size() > idx) ? sq[idx] : -1, zexp + BEATS + 1);
    if (en_cyc.size() >= (idx + 1) * BEATS) begin
      check({tag, "_en_first"}, en_cyc[idx*BEATS], zexp + 1);
      check({tag, "_en_last"}, en_cyc[idx*BEATS + BEATS - 1], zexp + BEATS);
      for (int r = 0; r < BEATS; r++)
        if (en_dat[idx*BEATS + r] !== beat_of(pix, r)) bad++;
    end else begin
      bad = BEATS;
    end
    check({tag, "_bad_beats"}, bad, 0);
  endtask

  pixel_t win[INPUTS], w1[INPUTS], w2[INPUTS], w3[INPUTS];
  int     last, l1, l2, l3, ones;

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_d = '0;

    //           rst clr vld  rdy busy z en s
    vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 6; i++) begin
      rst_n = vec[i].rst_n; clr = vec[i].clr; in_valid = vec[i].vld;
      for (int l = 0; l < LANES; l++) in_d[l] = pixel_t'($urandom);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), in_ready, vec[i].e_rdy);
      check($sformatf("vec%0d_busy", i), busy, vec[i].e_busy);
      check($sformatf("vec%0d_z", i), z, vec[i].e_z);
      check($sformatf("vec%0d_en", i), en, vec[i].e_en);
      check($sformatf("vec%0d_sample", i), sample, vec[i].e_s);
      if (i == 0) check("vec0_d_reset", longint'(d), 0);
    end
    clr = 1'b0; in_valid = 1'b0;

    // Incrementing window, no gaps
    for (int i = 0; i < INPUTS; i++) win[i] = pixel_t'(i);
    clear_mon();
    send_window(win, 0, last);
    idle_in();
    wait_until(last + BEATS + 10);
    check_window(win, last + 1, 0, "inc");
    check("inc_beat3", (en_dat.size() > 3) ? longint'(en_dat[3]) : -1,
          longint'({8'd19, 8'd18, 8'd17, 8'd16, 8'd15}));
    check("inc_sample_count", sq.size(), 1);
`ifdef A_FEEDER_PINGPONG_EN
    check("inc_rdy_after_fill", rdy_at[last + 1], 1);
`else
    ones = 0;
    for (int c = last + 1; c <= last + BEATS + 2; c++) ones += int'(rdy_at[c]);
    check("inc_rdy_low_window", ones, 0);
    check("inc_rdy_back", rdy_at[last + BEATS + 3], 1);
`endif

    // Random pixels with random valid gaps
    rand_win(win);
    clear_mon();
    send_window(win, 30, last);
    idle_in();
    wait_until(last + BEATS + 10);
    check_window(win, last + 1, 0, "gap");
    check("gap_sample_count", sq.size(), 1);

    // clr on stream beat 40, with a beat presented in the same cycle
    rand_win(win);
    clear_mon();
    send_window(win, 10, last);
    idle_in();
    wait_until(last + 2 + 40);
    check("clr_beat40_d", longint'(d), longint'(beat_of(win, 40)));
    clr = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    check("clr_en_after", en, 0);
    check("clr_busy_after", busy, 0);
    wait_until(cyc + 100);
    check("clr_no_sample", sq.size(), 0);
    rand_win(win);
    clear_mon();
    send_window(win, 20, last);
    idle_in();
    wait_until(last + BEATS + 10);
    check_window(win, last + 1, 0, "postclr");

`ifdef A_FEEDER_PINGPONG_EN
    // Continuous windows: 0x11, 0x22, then random
    for (int i = 0; i < INPUTS; i++) begin w1[i] = 8'h11; w2[i] = 8'h22; end
    rand_win(w3);
    clear_mon();
    send_window(w1, 0, l1);
    send_window(w2, 0, l2);
    send_window(w3, 0, l3);
    idle_in();
    wait_until(l1 + 3*BEATS + 20);
    check("pp_fill_spacing", l2 - l1, BEATS);
    check("pp_rdy_both_full", rdy_at[l1 + BEATS + 1], 0);
    check("pp_rdy_release", rdy_at[l1 + BEATS + 3], 1);
    check("pp_sample_gap", (sq.size() > 1) ? sq[1] - sq[0] : -1, BEATS + 2);
    check_window(w1, l1 + 1, 0, "pp1");
    check_window(w2, l1 + BEATS + 3, 1, "pp2");
    check_window(w3, l1 + 2*BEATS + 5, 2, "pp3");
`else
    // Upstream always valid: second window waits for the first one's sample
    rand_win(w1);
    rand_win(w2);
    clear_mon();
    send_window(w1, 0, l1);
    send_window(w2, 0, l2);
    idle_in();
    wait_until(l2 + BEATS + 10);
    check("b2b_fill_spacing", l2 - l1, 2*BEATS + 2);
    check("b2b_sample_gap", (sq.size() > 1) ? sq[1] - sq[0] : -1, 2*BEATS + 2);
    check_window(w1, l1 + 1, 0, "b2b1");
    check_window(w2, l2 + 1, 1, "b2b2");
`endif

    // Asynchronous reset mid-stream
    rand_win(win);
    clear_mon();
    send_window(win, 0, last);
    idle_in();
    wait_until(last + 20);
    check("rst_pre_en", en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_en", en, 0);
    check("rst_async_z_s", {z, sample}, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_rdy", in_ready, 0);
    check("rst_async_d", longint'(d), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    wait_until(cyc + 120);
    check("rst_no_sample", sq.size(), 0);
    rand_win(win);
    send_window(win, 15, last);
    idle_in();
    wait_until(last + BEATS + 10);
    check_window(win, last + 1, 0, "postrst");

    check("z_en_overlap", zen_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
